// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the execute stage.
// Holds opcodes, FSM states, flag positions and the control bundle.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_MUL  = 4'd8,
        ALU_PASS = 4'd9
    } aluop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Bit positions inside the {Z,N,V} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       regdst;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] memtoreg;
    } ctrl_t;

    function automatic logic [2:0] mk_flags(
        input logic zero,
        input logic neg,
        input logic ovf
    );
        logic [2:0] f;
        f         = '0;
        f[FLAG_Z] = zero;
        f[FLAG_N] = neg;
        f[FLAG_V] = ovf;
        return f;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// mul_iter: iterative shift-add multiplier, one partial product per cycle.
// Ports: clk/rst, start/abort, operands a/b, done strobe, product (low DATA_W bits).
module mul_iter
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CW = $clog2(DATA_W);

    logic              busy;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;

    // Product including the iteration performed at the upcoming edge,
    // so the final value is usable on the same edge that retires it.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (count == CW'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage; single-cycle ALU, iterative multiply, EX/MEM register.
// Ports: id_* decoded inputs, flush, ex_stall to decode, mem_* registered outputs.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_aluop,
    input  logic [DATA_W-1:0] id_src1,
    input  logic [DATA_W-1:0] id_src2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic [1:0]        id_memtoreg,
    input  logic              flush,
    output logic              ex_stall,
    output logic              mem_valid,
    output logic              mem_regdst_out,
    output logic              mem_regwrite_out,
    output logic              mem_memread_out,
    output logic              mem_memwrite_out,
    output logic [1:0]        mem_memtoreg_out,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_alu_src2_out,
    output logic [2:0]        mem_flags
);

    state_e            state;
    ctrl_t             id_ctrl;
    ctrl_t             held_ctrl;
    ctrl_t             ctrl_q;
    logic [DATA_W-1:0] held_src2;

    logic [DATA_W-1:0] op_b;
    logic [3:0]        shamt;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic              accept;
    logic              is_mul;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_prod;

    logic              nxt_valid;
    ctrl_t             nxt_ctrl;
    logic [DATA_W-1:0] nxt_alu;
    logic [DATA_W-1:0] nxt_src2;
    logic [2:0]        nxt_flags;

    assign id_ctrl   = {id_regdst, id_regwrite, id_memread,
                        id_memwrite, id_memtoreg};
    assign ex_stall  = (state == ST_MUL);
    assign accept    = id_valid && !ex_stall && !flush;
    assign is_mul    = (id_aluop == ALU_MUL);
    assign mul_start = accept && is_mul;
    assign op_b      = id_alusrc ? id_imm : id_src2;
    assign shamt     = op_b[3:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (id_aluop)
            ALU_ADD: begin
                alu_res = id_src1 + op_b;
                alu_ovf = (id_src1[DATA_W-1] == op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != id_src1[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_res = id_src1 - op_b;
                alu_ovf = (id_src1[DATA_W-1] != op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != id_src1[DATA_W-1]);
            end
            ALU_AND:  alu_res = id_src1 & op_b;
            ALU_OR:   alu_res = id_src1 | op_b;
            ALU_XOR:  alu_res = id_src1 ^ op_b;
            ALU_SLL:  alu_res = id_src1 << shamt;
            ALU_SRL:  alu_res = id_src1 >> shamt;
            ALU_SRA:  alu_res = $signed(id_src1) >>> shamt;
            ALU_PASS: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (flush),
        .a       (id_src1),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Next EX/MEM contents; anything not selected below is a bubble.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_ctrl  = '0;
        nxt_alu   = '0;
        nxt_src2  = '0;
        nxt_flags = '0;
        if (flush) begin
            nxt_valid = 1'b0;
        end else if (mul_done) begin
            nxt_valid = 1'b1;
            nxt_ctrl  = held_ctrl;
            nxt_alu   = mul_prod;
            nxt_src2  = held_src2;
            nxt_flags = mk_flags(mul_prod == '0,
                                 mul_prod[DATA_W-1], 1'b0);
        end else if (accept && !is_mul) begin
            nxt_valid = 1'b1;
            nxt_ctrl  = id_ctrl;
            nxt_alu   = alu_res;
            nxt_src2  = id_src2;
            nxt_flags = mk_flags(alu_res == '0,
                                 alu_res[DATA_W-1], alu_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            held_ctrl        <= '0;
            held_src2        <= '0;
            mem_valid        <= 1'b0;
            ctrl_q           <= '0;
            mem_alu_out      <= '0;
            mem_alu_src2_out <= '0;
            mem_flags        <= '0;
        end else begin
            mem_valid        <= nxt_valid;
            ctrl_q           <= nxt_ctrl;
            mem_alu_out      <= nxt_alu;
            mem_alu_src2_out <= nxt_src2;
            mem_flags        <= nxt_flags;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: if (mul_start) state <= ST_MUL;
                    ST_MUL:  if (mul_done)  state <= ST_IDLE;
                endcase
            end
            if (mul_start) begin
                held_ctrl <= id_ctrl;
                held_src2 <= id_src2;
            end
        end
    end

    assign mem_regdst_out   = ctrl_q.regdst;
    assign mem_regwrite_out = ctrl_q.regwrite;
    assign mem_memread_out  = ctrl_q.memread;
    assign mem_memwrite_out = ctrl_q.memwrite;
    assign mem_memtoreg_out = ctrl_q.memtoreg;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized + directed bench for ex_stage.
// A behavioural model predicts every EX/MEM update and the stall line.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_aluop;
    logic [15:0] id_src1;
    logic [15:0] id_src2;
    logic [15:0] id_imm;
    logic        id_alusrc;
    logic        id_regdst;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_memwrite;
    logic [1:0]  id_memtoreg;
    logic        flush;
    logic        ex_stall;
    logic        mem_valid;
    logic        mem_regdst_out;
    logic        mem_regwrite_out;
    logic        mem_memread_out;
    logic        mem_memwrite_out;
    logic [1:0]  mem_memtoreg_out;
    logic [15:0] mem_alu_out;
    logic [15:0] mem_alu_src2_out;
    logic [2:0]  mem_flags;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_aluop         (id_aluop),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_imm           (id_imm),
        .id_alusrc        (id_alusrc),
        .id_regdst        (id_regdst),
        .id_regwrite      (id_regwrite),
        .id_memread       (id_memread),
        .id_memwrite      (id_memwrite),
        .id_memtoreg      (id_memtoreg),
        .flush            (flush),
        .ex_stall         (ex_stall),
        .mem_valid        (mem_valid),
        .mem_regdst_out   (mem_regdst_out),
        .mem_regwrite_out (mem_regwrite_out),
        .mem_memread_out  (mem_memread_out),
        .mem_memwrite_out (mem_memwrite_out),
        .mem_memtoreg_out (mem_memtoreg_out),
        .mem_alu_out      (mem_alu_out),
        .mem_alu_src2_out (mem_alu_src2_out),
        .mem_flags        (mem_flags)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Expected outputs: {valid, ctrl[5:0], alu, src2, flags{Z,N,V}, stall}
    typedef struct packed {
        logic        v;
        logic [5:0]  ctrl;
        logic [15:0] alu;
        logic [15:0] src2;
        logic [2:0]  flags;
        logic        stall;
    } exp_t;

    exp_t        exp_o;
    bit          chk_en = 1'b0;
    int          mul_left = 0;
    logic [15:0] m_res;
    logic [15:0] m_src2;
    logic [5:0]  m_ctrl;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Reference ALU from plain integer arithmetic.
    task automatic alu_ref(input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, output logic [15:0] r,
                           output logic v);
        int          sa, sb, s;
        int unsigned ua, ub, sh;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = a;
        ub = b;
        sh = ub % 16;
        v  = 1'b0;
        case (op)
            4'd0: begin s = sa + sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            4'd1: begin s = sa - sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin ua = (ua << sh); r = ua[15:0]; end
            4'd6: begin ua = (ua >> sh); r = ua[15:0]; end
            4'd7: begin s = sa >>> sh; r = s[15:0]; end
            4'd8: begin ua = ua * ub; r = ua[15:0]; end
            4'd9: r = b;
            default: r = 16'h0000;
        endcase
    endtask

    // Predict the edge about to happen from the current inputs, then
    // advance to the following falling edge.
    task automatic step();
        logic [15:0] b;
        logic [15:0] r;
        logic        v;
        exp_t        e;
        e = '0;
        b = id_alusrc ? id_imm : id_src2;
        if (rst || flush) begin
            mul_left = 0;
        end else if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin
                e.v     = 1'b1;
                e.ctrl  = m_ctrl;
                e.alu   = m_res;
                e.src2  = m_src2;
                e.flags = {m_res == 16'h0, m_res[15], 1'b0};
            end
        end else if (id_valid) begin
            alu_ref(id_aluop, id_src1, b, r, v);
            if (id_aluop == 4'd8) begin
                mul_left = 16;
                m_res    = r;
                m_src2   = id_src2;
                m_ctrl   = {id_regdst, id_regwrite, id_memread,
                            id_memwrite, id_memtoreg};
            end else begin
                e.v     = 1'b1;
                e.ctrl  = {id_regdst, id_regwrite, id_memread,
                           id_memwrite, id_memtoreg};
                e.alu   = r;
                e.src2  = id_src2;
                e.flags = {r == 16'h0, r[15], v};
            end
        end
        e.stall = (mul_left > 0);
        exp_o   = e;
        chk_en  = 1'b1;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cycle", {mem_valid, mem_regdst_out, mem_regwrite_out,
                            mem_memread_out, mem_memwrite_out,
                            mem_memtoreg_out, mem_alu_out,
                            mem_alu_src2_out, mem_flags, ex_stall},
                  exp_o);
        end
    end

    task automatic drive(input bit v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] s2,
                         input logic [15:0] imm, input bit asrc,
                         input logic [5:0] ctrl);
        id_valid    = v;
        id_aluop    = op;
        id_src1     = a;
        id_src2     = s2;
        id_imm      = imm;
        id_alusrc   = asrc;
        {id_regdst, id_regwrite, id_memread,
         id_memwrite, id_memtoreg} = ctrl;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    int stall_cnt;

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 6'h0);
        step();
        step();
        check("reset_valid", mem_valid, 1'b0);
        check("reset_alu", mem_alu_out, 16'h0000);
        check("reset_stall", ex_stall, 1'b0);
        rst = 1'b0;

        // ADD overflow into sign bit
        drive(1'b1, 4'd0, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 6'b010000);
        step();
        check("add_res", mem_alu_out, 16'h8000);
        check("add_flags", mem_flags, 3'b011);
        check("add_valid", mem_valid, 1'b1);
        check("add_stall", ex_stall, 1'b0);

        drive(1'b1, 4'd7, 16'h8000, 16'h0, 16'h0004, 1'b1, 6'b010000);
        step();
        check("sra", mem_alu_out, 16'hF800);
        drive(1'b1, 4'd6, 16'h8000, 16'h0, 16'h0004, 1'b1, 6'b010000);
        step();
        check("srl", mem_alu_out, 16'h0800);

        // Store: address from immediate, data from src2
        drive(1'b1, 4'd0, 16'h0100, 16'hBEEF, 16'h0004, 1'b1, 6'b000100);
        step();
        check("st_addr", mem_alu_out, 16'h0104);
        check("st_data", mem_alu_src2_out, 16'hBEEF);
        check("st_memwrite", mem_memwrite_out, 1'b1);

        // Multiply with a dependent ADD held in decode
        drive(1'b1, 4'd8, 16'h0123, 16'h0045, 16'h0, 1'b0, 6'b110000);
        step();
        drive(1'b1, 4'd0, 16'h0010, 16'h0020, 16'h0, 1'b0, 6'b110000);
        stall_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (ex_stall) stall_cnt++;
            if (ex_stall && mem_valid)
                check("mul_bubble", mem_valid, 1'b0);
            step();
        end
        check("mul_stall_cycles", stall_cnt, 16);
        check("mul_res", mem_alu_out, 16'h4E6F);
        check("mul_valid", mem_valid, 1'b1);
        check("mul_stall_low", ex_stall, 1'b0);
        step();
        check("held_add", mem_alu_out, 16'h0030);

        // Flush five cycles into a multiply
        drive(1'b1, 4'd8, 16'h0123, 16'h0045, 16'h0, 1'b0, 6'b110000);
        step();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 6'h0);
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_bubble", mem_valid, 1'b0);
        check("flush_stall", ex_stall, 1'b0);
        for (int i = 0; i < 20; i++) step();

        // Reset five cycles into a multiply
        drive(1'b1, 4'd8, 16'h0123, 16'h0045, 16'h0, 1'b0, 6'b110000);
        step();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 6'h0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outs", {mem_valid, mem_alu_out, mem_flags, ex_stall},
              20'h0);
        for (int i = 0; i < 20; i++) step();

        // Flush beats a valid ADD in IDLE
        drive(1'b1, 4'd0, 16'h0001, 16'h0002, 16'h0, 1'b0, 6'b010100);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_add", {mem_valid, mem_regwrite_out, mem_memwrite_out},
              3'b000);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  pick(), pick(), pick(), 1'($urandom),
                  6'($urandom));
            step();
        end
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 6'h0);
        for (int i = 0; i < 20; i++) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
